// File: rtl/reset_request_ctrl.sv
// Reset request controller: turns software or watchdog reset requests into a
// timed, handshaked EXT_RST_N sequence with the external reset controller.
module reset_request_ctrl #(
    parameter int PULSE_CYCLES = 16,
    parameter int WAIT_CYCLES  = 1024,
    parameter int WDT_CYCLES   = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_rst_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    input  logic       fabric_reset_n,
    output logic       ext_rst_n,
    output logic       rst_busy,
    output logic       rst_done,
    output logic       rst_timeout,
    output logic [1:0] cause
);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    localparam int TMAX   = (PULSE_CYCLES > WAIT_CYCLES) ? PULSE_CYCLES : WAIT_CYCLES;
    localparam int TCNT_W = $clog2(TMAX + 1);
    localparam int WDT_W  = $clog2(WDT_CYCLES + 1);

    localparam logic [TCNT_W-1:0] PULSE_LAST = TCNT_W'(PULSE_CYCLES - 1);
    localparam logic [TCNT_W-1:0] WAIT_LAST  = TCNT_W'(WAIT_CYCLES - 1);
    localparam logic [WDT_W-1:0]  WDT_LAST   = WDT_W'(WDT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [TCNT_W-1:0] tcnt;
    logic [TCNT_W-1:0] tcnt_next;
    logic [WDT_W-1:0]  wdt_cnt;
    logic              fr_meta;
    logic              fr_s;
    logic              wdt_fire;
    logic              accept;
    logic              timeout_set;
    logic              done_set;

    // fabric_reset_n comes from another reset domain; only fr_s is used below.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fr_meta <= 1'b1;
            fr_s    <= 1'b1;
        end else begin
            fr_meta <= fabric_reset_n;
            fr_s    <= fr_meta;
        end
    end

    assign wdt_fire = (state == IDLE) && wdt_en && !wdt_kick && (wdt_cnt == WDT_LAST);
    assign accept   = (state == IDLE) && (sw_rst_req || wdt_fire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_cnt <= '0;
        end else if (!wdt_en || (state != IDLE) || wdt_kick || wdt_fire) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end

    // The shared phase counter restarts on every state change and saturates.
    always_comb begin
        state_next  = state;
        timeout_set = 1'b0;
        done_set    = 1'b0;
        tcnt_next   = (tcnt == '1) ? tcnt : tcnt + TCNT_W'(1);

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ASSERT;
                end
            end
            ASSERT: begin
                if (tcnt == PULSE_LAST) begin
                    state_next = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!fr_s) begin
                    state_next = WAIT_HIGH;
                end else if (tcnt == WAIT_LAST) begin
                    state_next  = IDLE;
                    timeout_set = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (fr_s) begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                end else if (tcnt == WAIT_LAST) begin
                    state_next  = IDLE;
                    timeout_set = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next != state) begin
            tcnt_next = '0;
        end
    end

    // Outputs are registered from the next state so they change with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tcnt        <= '0;
            ext_rst_n   <= 1'b1;
            rst_busy    <= 1'b0;
            rst_done    <= 1'b0;
            rst_timeout <= 1'b0;
            cause       <= 2'b00;
        end else begin
            state     <= state_next;
            tcnt      <= tcnt_next;
            ext_rst_n <= !((state_next == ASSERT) || (state_next == WAIT_LOW));
            rst_busy  <= (state_next != IDLE);
            rst_done  <= done_set;
            if (accept) begin
                cause       <= wdt_fire ? 2'b10 : 2'b01;
                rst_timeout <= 1'b0;
            end else if (timeout_set) begin
                rst_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reset_request_ctrl.sv
// Directed self-checking bench for reset_request_ctrl with short timing
// parameters (pulse 4, wait 8, watchdog 16).
module tb_reset_request_ctrl;

    logic       clk;
    logic       reset;
    logic       swRstReq;
    logic       wdtEn;
    logic       wdtKick;
    logic       fabricResetN;
    logic       extRstN;
    logic       rstBusy;
    logic       rstDone;
    logic       rstTimeout;
    logic [1:0] cause;

    int assertCount;
    int failCount;
    int lowCount;
    int doneCount;
    int fallCount;
    logic prevExt;
    int n;

    reset_request_ctrl #(
        .PULSE_CYCLES(4),
        .WAIT_CYCLES (8),
        .WDT_CYCLES  (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sw_rst_req    (swRstReq),
        .wdt_en        (wdtEn),
        .wdt_kick      (wdtKick),
        .fabric_reset_n(fabricResetN),
        .ext_rst_n     (extRstN),
        .rst_busy      (rstBusy),
        .rst_done      (rstDone),
        .rst_timeout   (rstTimeout),
        .cause         (cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sw, input logic en, input logic kick);
        swRstReq = sw;
        wdtEn    = en;
        wdtKick  = kick;
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!extRstN) lowCount++;
        if (rstDone) doneCount++;
        if (prevExt && !extRstN) fallCount++;
        prevExt = extRstN;
    endtask

    task automatic clearMonitors();
        lowCount  = 0;
        doneCount = 0;
        fallCount = 0;
        prevExt   = 1'b1;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 1'b0, 1'b0);
        fabricResetN = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clearMonitors();
    endtask

    task automatic waitExtHigh(input int limit);
        int k;
        k = 0;
        while (!extRstN && k < limit) begin
            tick();
            k++;
        end
        if (!extRstN) checkOutput("ext_rise_bound", 32'(extRstN), 32'd1);
    endtask

    task automatic waitIdle(input int limit);
        int k;
        k = 0;
        while (rstBusy && k < limit) begin
            tick();
            k++;
        end
        if (rstBusy) checkOutput("idle_bound", 32'(rstBusy), 32'd0);
    endtask

    // Software request with a well-behaved reset controller model.
    task automatic runNormalSequence();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("seq_ext_low", 32'(extRstN), 32'd0);
        checkOutput("seq_busy", 32'(rstBusy), 32'd1);
        checkOutput("seq_cause_early", 32'(cause), 32'd1);
        repeat (2) tick();
        fabricResetN = 1'b0;
        waitExtHigh(30);
        repeat (3) tick();
        fabricResetN = 1'b1;
        waitIdle(30);
        repeat (2) tick();
        checkOutput("seq_low_cycles", 32'(lowCount), 32'd5);
        checkOutput("seq_done_pulses", 32'(doneCount), 32'd1);
        checkOutput("seq_cause", 32'(cause), 32'd1);
        checkOutput("seq_timeout", 32'(rstTimeout), 32'd0);
        checkOutput("seq_busy_end", 32'(rstBusy), 32'd0);
        checkOutput("seq_ext_end", 32'(extRstN), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_time_limit: observed expired, expected finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        assertCount = 0;
        failCount   = 0;
        clearMonitors();
        resetDut();

        checkOutput("rst_ext", 32'(extRstN), 32'd1);
        checkOutput("rst_busy", 32'(rstBusy), 32'd0);
        checkOutput("rst_done", 32'(rstDone), 32'd0);
        checkOutput("rst_timeout", 32'(rstTimeout), 32'd0);
        checkOutput("rst_cause", 32'(cause), 32'd0);

        $display("[TB] normal software sequence");
        runNormalSequence();

        $display("[TB] fabric never drops");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (15) tick();
        checkOutput("wl_low_cycles", 32'(lowCount), 32'd12);
        checkOutput("wl_timeout", 32'(rstTimeout), 32'd1);
        checkOutput("wl_done", 32'(doneCount), 32'd0);
        checkOutput("wl_busy", 32'(rstBusy), 32'd0);

        $display("[TB] watchdog expiry");
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b0);
        n = 0;
        while (extRstN && n < 40) begin
            tick();
            n++;
        end
        checkOutput("wdt_fall_cycle", 32'(n), 32'd16);
        checkOutput("wdt_cause", 32'(cause), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitIdle(30);
        checkOutput("wdt_timeout", 32'(rstTimeout), 32'd1);

        $display("[TB] watchdog with kick");
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b0);
        n = 0;
        while (extRstN && n < 60) begin
            n++;
            wdtKick = (n == 10);
            tick();
        end
        wdtKick = 1'b0;
        checkOutput("kick_fall_cycle", 32'(n), 32'd26);

        $display("[TB] coincident software and watchdog requests");
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (15) tick();
        checkOutput("co_ext_before", 32'(extRstN), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("co_ext_low", 32'(extRstN), 32'd0);
        checkOutput("co_cause_early", 32'(cause), 32'd2);
        for (int i = 1; i <= 23; i++) begin
            swRstReq = (i == 6);
            tick();
        end
        swRstReq = 1'b0;
        checkOutput("co_falls", 32'(fallCount), 32'd1);
        checkOutput("co_low_cycles", 32'(lowCount), 32'd12);
        checkOutput("co_cause", 32'(cause), 32'd2);
        checkOutput("co_busy", 32'(rstBusy), 32'd0);

        $display("[TB] reset during ASSERT");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("ab_cause_before", 32'(cause), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("ab_ext", 32'(extRstN), 32'd1);
        checkOutput("ab_busy", 32'(rstBusy), 32'd0);
        checkOutput("ab_done", 32'(rstDone), 32'd0);
        checkOutput("ab_cause", 32'(cause), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clearMonitors();
        tick();
        checkOutput("ab_done_after", 32'(doneCount), 32'd0);
        clearMonitors();
        runNormalSequence();

        $display("[TB] fabric stuck low after release");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        fabricResetN = 1'b0;
        waitExtHigh(30);
        repeat (7) tick();
        checkOutput("wh_timeout_early", 32'(rstTimeout), 32'd0);
        checkOutput("wh_busy_early", 32'(rstBusy), 32'd1);
        tick();
        checkOutput("wh_timeout", 32'(rstTimeout), 32'd1);
        checkOutput("wh_busy", 32'(rstBusy), 32'd0);
        checkOutput("wh_done", 32'(doneCount), 32'd0);
        fabricResetN = 1'b1;
        repeat (3) tick();
        checkOutput("wh_timeout_held", 32'(rstTimeout), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wh_timeout_cleared", 32'(rstTimeout), 32'd0);
        checkOutput("wh_ext_low", 32'(extRstN), 32'd0);
        checkOutput("wh_cause", 32'(cause), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
